// File: rtl/otp_ctrl_pkg.sv
// Shared types and default constants for the OTP / register-file xbus controller.
package otp_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        I2C_ACC,
        LOAD_RD,
        LOAD_WAIT,
        LOAD_WR,
        PGM_RD,
        PGM_STB,
        PGM_GAP
    } otp_ctrl_fsm_t;

    localparam int ADDR_W_DEF    = 4;
    localparam int NUM_WORDS_DEF = 16;
    localparam int RD_CYC_DEF    = 4;
    localparam int PGM_CYC_DEF   = 100;
    localparam int GAP_CYC_DEF   = 10;
    localparam int CNT_W_DEF     = 8;

endpackage

// File: rtl/otp_timer.sv
// Down-counter used to time OTP read latency, program pulse width and recovery gap.
// Loading N makes expire rise N cycles later, so the owner stays exactly N cycles in a state.
module otp_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             expire
);

    logic [CNT_W-1:0] count;

    // Count down from the loaded value and rest at zero once finished.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expire = (count == CNT_W'(1));

endmodule

// File: rtl/otp_xbus_ctrl.sv
// Owner of the register-file xbus: loads OTP into the register file after reset,
// burns register contents back into OTP on command, and otherwise serves I2C accesses.
module otp_xbus_ctrl
    import otp_ctrl_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int NUM_WORDS = NUM_WORDS_DEF,
    parameter int RD_CYC    = RD_CYC_DEF,
    parameter int PGM_CYC   = PGM_CYC_DEF,
    parameter int GAP_CYC   = GAP_CYC_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic              osc_clk,
    input  logic              otp_rst_n,
    input  logic              i2c_req,
    input  logic              i2c_wr,
    input  logic [ADDR_W-1:0] i2c_addr,
    input  logic [7:0]        i2c_wdata,
    output logic              i2c_ack,
    output logic [7:0]        i2c_rdata,
    output logic [ADDR_W-1:0] rf_addr,
    output logic              rf_wr,
    output logic [7:0]        rf_din,
    input  logic [7:0]        rf_dout,
    output logic [ADDR_W-1:0] otp_addr,
    output logic              otp_rd,
    input  logic [7:0]        otp_dout,
    output logic              otp_pgm,
    output logic [7:0]        otp_din,
    input  logic              load_start,
    input  logic              pgm_start,
    input  logic              pgm_en,
    output logic              busy,
    output logic              load_done,
    output logic              pgm_done
);

    localparam logic [ADDR_W-1:0] LAST_W = ADDR_W'(NUM_WORDS - 1);

    otp_ctrl_fsm_t     state;
    logic [ADDR_W-1:0] w;
    logic [7:0]        data;
    logic              i2c_armed;
    logic              timer_load;
    logic [CNT_W-1:0]  timer_value;
    logic              timer_expire;

    otp_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk    (osc_clk),
        .rst_n  (otp_rst_n),
        .load   (timer_load),
        .value  (timer_value),
        .expire (timer_expire)
    );

    // Start the timer on entry to each timed phase: read latency, burn width, then recovery gap.
    always_comb begin
        timer_load  = 1'b0;
        timer_value = '0;
        case (state)
            LOAD_RD: begin
                timer_load  = 1'b1;
                timer_value = CNT_W'(RD_CYC);
            end
            PGM_RD: begin
                if (rf_dout != 8'h00) begin
                    timer_load  = 1'b1;
                    timer_value = CNT_W'(PGM_CYC);
                end
            end
            PGM_STB: begin
                if (timer_expire) begin
                    timer_load  = 1'b1;
                    timer_value = CNT_W'(GAP_CYC);
                end
            end
            default: ;
        endcase
    end

    // Sequencer: every registered output is computed for the state being entered, so
    // buses fall back to zero whenever the next state performs no access.
    always_ff @(posedge osc_clk) begin
        if (!otp_rst_n) begin
            state     <= LOAD_RD;
            w         <= '0;
            data      <= '0;
            i2c_armed <= 1'b1;
            rf_addr   <= '0;
            rf_wr     <= 1'b0;
            rf_din    <= '0;
            otp_addr  <= '0;
            otp_pgm   <= 1'b0;
            otp_din   <= '0;
            i2c_ack   <= 1'b0;
            i2c_rdata <= '0;
            load_done <= 1'b0;
            pgm_done  <= 1'b0;
        end else begin
            rf_wr    <= 1'b0;
            rf_addr  <= '0;
            rf_din   <= '0;
            otp_addr <= '0;
            otp_pgm  <= 1'b0;
            otp_din  <= '0;
            i2c_ack  <= 1'b0;
            pgm_done <= 1'b0;
            if (!i2c_req) begin
                i2c_armed <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (pgm_start && pgm_en && load_done) begin
                        state   <= PGM_RD;
                        rf_addr <= w;
                    end else if (load_start) begin
                        state     <= LOAD_RD;
                        load_done <= 1'b0;
                        otp_addr  <= w;
                    end else if (i2c_req && i2c_armed) begin
                        state     <= I2C_ACC;
                        i2c_armed <= 1'b0;
                        rf_addr   <= i2c_addr;
                        if (i2c_wr) begin
                            rf_wr  <= 1'b1;
                            rf_din <= i2c_wdata;
                        end
                    end
                end
                I2C_ACC: begin
                    state   <= IDLE;
                    i2c_ack <= 1'b1;
                    if (!i2c_wr) begin
                        i2c_rdata <= rf_dout;
                    end
                end
                LOAD_RD: begin
                    state    <= LOAD_WAIT;
                    otp_addr <= w;
                end
                LOAD_WAIT: begin
                    if (timer_expire) begin
                        state   <= LOAD_WR;
                        data    <= otp_dout;
                        rf_wr   <= 1'b1;
                        rf_addr <= w;
                        rf_din  <= otp_dout;
                    end else begin
                        otp_addr <= w;
                    end
                end
                LOAD_WR: begin
                    if (w == LAST_W) begin
                        state     <= IDLE;
                        w         <= '0;
                        load_done <= 1'b1;
                    end else begin
                        state    <= LOAD_RD;
                        w        <= w + 1'b1;
                        otp_addr <= w + 1'b1;
                    end
                end
                PGM_RD: begin
                    if (rf_dout != 8'h00) begin
                        state    <= PGM_STB;
                        data     <= rf_dout;
                        otp_pgm  <= 1'b1;
                        otp_addr <= w;
                        otp_din  <= rf_dout;
                    end else if (w == LAST_W) begin
                        state    <= IDLE;
                        w        <= '0;
                        pgm_done <= 1'b1;
                    end else begin
                        state   <= PGM_RD;
                        w       <= w + 1'b1;
                        rf_addr <= w + 1'b1;
                    end
                end
                PGM_STB: begin
                    otp_addr <= w;
                    if (timer_expire) begin
                        state <= PGM_GAP;
                    end else begin
                        otp_pgm <= 1'b1;
                        otp_din <= data;
                    end
                end
                PGM_GAP: begin
                    if (!timer_expire) begin
                        otp_addr <= w;
                    end else if (w == LAST_W) begin
                        state    <= IDLE;
                        w        <= '0;
                        pgm_done <= 1'b1;
                    end else begin
                        state   <= PGM_RD;
                        w       <= w + 1'b1;
                        rf_addr <= w + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // LOAD_RD is entered straight from reset, so the read strobe is decoded from the
    // state rather than registered; the reset term keeps it quiet while reset is held.
    assign otp_rd = otp_rst_n && (state == LOAD_RD);
    assign busy   = (state != IDLE);

endmodule

// File: tb/tb_otp_xbus_ctrl.sv
// Directed self-checking bench for otp_xbus_ctrl with behavioural register-file and OTP models.
module tb_otp_xbus_ctrl;

    localparam int ADDR_W    = 4;
    localparam int NUM_WORDS = 16;
    localparam int RD_CYC    = 4;
    localparam int PGM_CYC   = 100;
    localparam int GAP_CYC   = 10;
    localparam int CNT_W     = 8;

    logic              osc_clk = 1'b0;
    logic              otp_rst_n = 1'b0;
    logic              i2c_req = 1'b0;
    logic              i2c_wr = 1'b0;
    logic [ADDR_W-1:0] i2c_addr = '0;
    logic [7:0]        i2c_wdata = '0;
    logic              i2c_ack;
    logic [7:0]        i2c_rdata;
    logic [ADDR_W-1:0] rf_addr;
    logic              rf_wr;
    logic [7:0]        rf_din;
    logic [7:0]        rf_dout;
    logic [ADDR_W-1:0] otp_addr;
    logic              otp_rd;
    logic [7:0]        otp_dout;
    logic              otp_pgm;
    logic [7:0]        otp_din;
    logic              load_start = 1'b0;
    logic              pgm_start = 1'b0;
    logic              pgm_en = 1'b0;
    logic              busy;
    logic              load_done;
    logic              pgm_done;

    int checks = 0;
    int errors = 0;

    otp_xbus_ctrl #(
        .ADDR_W(ADDR_W), .NUM_WORDS(NUM_WORDS), .RD_CYC(RD_CYC),
        .PGM_CYC(PGM_CYC), .GAP_CYC(GAP_CYC), .CNT_W(CNT_W)
    ) dut (
        .osc_clk(osc_clk), .otp_rst_n(otp_rst_n),
        .i2c_req(i2c_req), .i2c_wr(i2c_wr), .i2c_addr(i2c_addr), .i2c_wdata(i2c_wdata),
        .i2c_ack(i2c_ack), .i2c_rdata(i2c_rdata),
        .rf_addr(rf_addr), .rf_wr(rf_wr), .rf_din(rf_din), .rf_dout(rf_dout),
        .otp_addr(otp_addr), .otp_rd(otp_rd), .otp_dout(otp_dout),
        .otp_pgm(otp_pgm), .otp_din(otp_din),
        .load_start(load_start), .pgm_start(pgm_start), .pgm_en(pgm_en),
        .busy(busy), .load_done(load_done), .pgm_done(pgm_done)
    );

    always #5 osc_clk = ~osc_clk;

    // Register file model: synchronous write, combinational read.
    logic [7:0] rf_mem [NUM_WORDS];
    always @(posedge osc_clk) begin
        if (rf_wr) rf_mem[rf_addr] <= rf_din;
    end
    assign rf_dout = rf_mem[rf_addr];

    // OTP model: word k holds A0+k; data is garbage until RD_CYC edges after the strobe.
    logic [ADDR_W-1:0] rd_addr = '0;
    int                rd_cnt = 0;
    always @(posedge osc_clk) begin
        if (otp_rd) begin
            rd_addr <= otp_addr;
            rd_cnt  <= RD_CYC;
        end else if (rd_cnt != 0) begin
            rd_cnt <= rd_cnt - 1;
        end
    end
    assign otp_dout = (rd_cnt <= 1) ? (8'hA0 + 8'(rd_addr)) : 8'hEE;

    // Monitor: records each program pulse with its address, data, width and preceding gap.
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        din;
        int                gap;
        int                width;
    } pulse_t;
    pulse_t            pulses[$];
    int                hold_err = 0;
    int                high_run = 0;
    int                low_run = 0;
    logic              pgm_prev = 1'b0;
    int                rfw_cnt = 0;
    logic [ADDR_W-1:0] last_rfw_addr = '0;
    logic [7:0]        last_rfw_data = '0;
    int                ack_cnt = 0;
    int                done_cnt = 0;
    always @(negedge osc_clk) begin
        if (otp_pgm) begin
            if (!pgm_prev) begin
                pulses.push_back('{otp_addr, otp_din, low_run, 0});
                high_run = 1;
            end else begin
                high_run++;
                if (otp_addr !== pulses[pulses.size()-1].addr ||
                    otp_din !== pulses[pulses.size()-1].din) hold_err++;
            end
        end else begin
            if (pgm_prev) begin
                pulses[pulses.size()-1].width = high_run;
                low_run = 1;
            end else begin
                low_run++;
            end
        end
        pgm_prev = otp_pgm;
        if (rf_wr) begin
            rfw_cnt++;
            last_rfw_addr = rf_addr;
            last_rfw_data = rf_din;
        end
        if (i2c_ack) ack_cnt++;
        if (pgm_done) done_cnt++;
    end

    task automatic wait_cycle();
        @(negedge osc_clk);
        #1;
    endtask

    // Drives one I2C access and waits for its ack; lat is -1 on timeout.
    task automatic i2c_access(input logic wr, input logic [ADDR_W-1:0] addr,
                              input logic [7:0] wdata, output int lat);
        i2c_req = 1'b1; i2c_wr = wr; i2c_addr = addr; i2c_wdata = wdata;
        lat = -1;
        for (int n = 1; n <= 4000; n++) begin
            wait_cycle();
            if (i2c_ack) begin
                lat = n;
                break;
            end
        end
        i2c_req = 1'b0;
        wait_cycle();
    endtask

    task automatic test_reset();
        otp_rst_n = 1'b0;
        repeat (3) wait_cycle();
        checks++; if (otp_rd !== 1'b0) begin errors++; $display("[TB] FAIL reset_otp_rd: got %b expected 0", otp_rd); end
        checks++; if (otp_pgm !== 1'b0) begin errors++; $display("[TB] FAIL reset_otp_pgm: got %b expected 0", otp_pgm); end
        checks++; if (rf_wr !== 1'b0) begin errors++; $display("[TB] FAIL reset_rf_wr: got %b expected 0", rf_wr); end
        checks++; if (i2c_ack !== 1'b0) begin errors++; $display("[TB] FAIL reset_i2c_ack: got %b expected 0", i2c_ack); end
        checks++; if (i2c_rdata !== 8'h00) begin errors++; $display("[TB] FAIL reset_i2c_rdata: got %h expected 00", i2c_rdata); end
        checks++; if (load_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_load_done: got %b expected 0", load_done); end
        checks++; if (pgm_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_pgm_done: got %b expected 0", pgm_done); end
    endtask

    task automatic test_load();
        int rfw0;
        rfw0 = rfw_cnt;
        otp_rst_n = 1'b1;
        #1;
        checks++; if (otp_rd !== 1'b1 || otp_addr !== 4'd0) begin errors++; $display("[TB] FAIL load_first_rd: got rd=%b addr=%0d expected rd=1 addr=0", otp_rd, otp_addr); end
        for (int n = 1; n <= 96; n++) begin
            wait_cycle();
            if (n == 1) begin
                checks++; if (otp_rd !== 1'b0) begin errors++; $display("[TB] FAIL load_rd_single: got %b expected 0", otp_rd); end
            end
            if (n == 95) begin
                checks++; if (load_done !== 1'b0) begin errors++; $display("[TB] FAIL load_done_early: got %b expected 0", load_done); end
            end
        end
        checks++; if (load_done !== 1'b1) begin errors++; $display("[TB] FAIL load_done_96: got %b expected 1", load_done); end
        checks++; if (rfw_cnt - rfw0 !== 16) begin errors++; $display("[TB] FAIL load_rf_writes: got %0d expected 16", rfw_cnt - rfw0); end
        for (int k = 0; k < NUM_WORDS; k++) begin
            checks++; if (rf_mem[k] !== 8'hA0 + 8'(k)) begin errors++; $display("[TB] FAIL load_rf_word%0d: got %h expected %h", k, rf_mem[k], 8'hA0 + 8'(k)); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL load_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_i2c();
        int lat;
        int rfw0;
        int a0;
        rfw0 = rfw_cnt;
        i2c_access(1'b1, 4'd3, 8'h5A, lat);
        checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL i2c_wr_latency: got %0d expected 2", lat); end
        checks++; if (rfw_cnt - rfw0 !== 1 || last_rfw_addr !== 4'd3 || last_rfw_data !== 8'h5A) begin
            errors++; $display("[TB] FAIL i2c_wr_strobe: got n=%0d addr=%0d data=%h expected n=1 addr=3 data=5a", rfw_cnt - rfw0, last_rfw_addr, last_rfw_data);
        end
        rfw0 = rfw_cnt;
        i2c_access(1'b0, 4'd3, 8'h00, lat);
        checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL i2c_rd_latency: got %0d expected 2", lat); end
        checks++; if (i2c_rdata !== 8'h5A) begin errors++; $display("[TB] FAIL i2c_rdata: got %h expected 5a", i2c_rdata); end
        checks++; if (rfw_cnt !== rfw0) begin errors++; $display("[TB] FAIL i2c_rd_no_write: got %0d writes expected 0", rfw_cnt - rfw0); end
        a0 = ack_cnt;
        i2c_req = 1'b1; i2c_wr = 1'b0; i2c_addr = 4'd9;
        repeat (6) wait_cycle();
        i2c_req = 1'b0;
        repeat (3) wait_cycle();
        checks++; if (ack_cnt - a0 !== 1) begin errors++; $display("[TB] FAIL i2c_held_req_acks: got %0d expected 1", ack_cnt - a0); end
        checks++; if (i2c_rdata !== 8'hA9) begin errors++; $display("[TB] FAIL i2c_rdata_hold: got %h expected a9", i2c_rdata); end
    endtask

    task automatic test_program();
        int lat;
        int bad_setup;
        int p0;
        int d0;
        int h0;
        int n;
        logic [ADDR_W-1:0] ea;
        bad_setup = 0;
        // Offsets keep every word nonzero except word 2.
        for (int k = 0; k < NUM_WORDS; k++) begin
            i2c_access(1'b1, 4'(k), (k == 2) ? 8'h00 : 8'h30 + 8'(k), lat);
            if (lat != 2) bad_setup++;
        end
        checks++; if (bad_setup !== 0) begin errors++; $display("[TB] FAIL pgm_setup_writes: got %0d bad expected 0", bad_setup); end
        p0 = pulses.size(); d0 = done_cnt; h0 = hold_err;
        pgm_en = 1'b1; pgm_start = 1'b1;
        wait_cycle();
        pgm_start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL pgm_busy: got %b expected 1", busy); end
        n = 0;
        for (int c = 1; c <= 3000; c++) begin
            wait_cycle();
            if (pgm_done) begin n = c; break; end
        end
        checks++; if (n !== 1666) begin errors++; $display("[TB] FAIL pgm_duration: got %0d expected 1666", n); end
        wait_cycle();
        checks++; if (pgm_done !== 1'b0 || done_cnt - d0 !== 1) begin errors++; $display("[TB] FAIL pgm_done_pulse: got level=%b count=%0d expected 0 and 1", pgm_done, done_cnt - d0); end
        checks++; if (pulses.size() - p0 !== 15) begin errors++; $display("[TB] FAIL pgm_pulse_count: got %0d expected 15", pulses.size() - p0); end
        checks++; if (hold_err !== h0) begin errors++; $display("[TB] FAIL pgm_hold: got %0d changes expected 0", hold_err - h0); end
        for (int i = 0; i < 15 && p0 + i < pulses.size(); i++) begin
            ea = (i < 2) ? 4'(i) : 4'(i + 1);
            checks++; if (pulses[p0+i].addr !== ea || pulses[p0+i].din !== 8'h30 + 8'(ea)) begin
                errors++; $display("[TB] FAIL pgm_word%0d: got addr=%0d din=%h expected addr=%0d din=%h", i, pulses[p0+i].addr, pulses[p0+i].din, ea, 8'h30 + 8'(ea));
            end
            checks++; if (pulses[p0+i].width !== 100) begin errors++; $display("[TB] FAIL pgm_width%0d: got %0d expected 100", i, pulses[p0+i].width); end
            if (i > 0) begin
                checks++; if (pulses[p0+i].gap !== ((i == 2) ? 12 : 11)) begin errors++; $display("[TB] FAIL pgm_gap%0d: got %0d expected %0d", i, pulses[p0+i].gap, (i == 2) ? 12 : 11); end
            end
        end
    endtask

    task automatic test_pgm_invalid();
        int p0;
        int n;
        p0 = pulses.size();
        pgm_en = 1'b0; pgm_start = 1'b1;
        wait_cycle();
        pgm_start = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL pgm_disabled_busy: got %b expected 0", busy); end
        repeat (20) wait_cycle();
        checks++; if (pulses.size() !== p0) begin errors++; $display("[TB] FAIL pgm_disabled_pulses: got %0d expected 0", pulses.size() - p0); end
        pgm_en = 1'b1; load_start = 1'b1;
        wait_cycle();
        load_start = 1'b0;
        checks++; if (busy !== 1'b1 || load_done !== 1'b0 || otp_rd !== 1'b1) begin
            errors++; $display("[TB] FAIL reload_start: got busy=%b done=%b rd=%b expected 1 0 1", busy, load_done, otp_rd);
        end
        n = 0;
        for (int c = 1; c <= 200; c++) begin
            wait_cycle();
            if (c == 5) pgm_start = 1'b1;
            if (c == 6) pgm_start = 1'b0;
            if (load_done) begin n = c; break; end
        end
        checks++; if (n !== 96) begin errors++; $display("[TB] FAIL reload_duration: got %0d expected 96", n); end
        repeat (20) wait_cycle();
        checks++; if (pulses.size() !== p0) begin errors++; $display("[TB] FAIL pgm_during_load_pulses: got %0d expected 0", pulses.size() - p0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL pgm_during_load_busy: got %b expected 0", busy); end
        checks++; if (rf_mem[2] !== 8'hA2) begin errors++; $display("[TB] FAIL reload_word2: got %h expected a2", rf_mem[2]); end
    endtask

    task automatic test_pgm_with_i2c();
        int a0;
        int n;
        int m;
        a0 = ack_cnt;
        i2c_req = 1'b1; i2c_wr = 1'b0; i2c_addr = 4'd7;
        pgm_en = 1'b1; pgm_start = 1'b1;
        wait_cycle();
        pgm_start = 1'b0;
        checks++; if (busy !== 1'b1 || otp_pgm !== 1'b0) begin errors++; $display("[TB] FAIL prio_pgm_first: got busy=%b pgm=%b expected 1 0", busy, otp_pgm); end
        n = 0;
        for (int c = 1; c <= 3000; c++) begin
            wait_cycle();
            if (pgm_done) begin n = c; break; end
        end
        checks++; if (n !== 1776) begin errors++; $display("[TB] FAIL prio_pgm_duration: got %0d expected 1776", n); end
        checks++; if (ack_cnt !== a0) begin errors++; $display("[TB] FAIL prio_early_ack: got %0d expected 0", ack_cnt - a0); end
        m = 0;
        for (int c = 1; c <= 10; c++) begin
            wait_cycle();
            if (i2c_ack) begin m = c; break; end
        end
        i2c_req = 1'b0;
        checks++; if (m !== 2) begin errors++; $display("[TB] FAIL prio_ack_latency: got %0d expected 2", m); end
        checks++; if (i2c_rdata !== 8'hA7) begin errors++; $display("[TB] FAIL prio_rdata: got %h expected a7", i2c_rdata); end
        wait_cycle();
    endtask

    task automatic test_reset_mid_pgm();
        int found;
        int rfw0;
        found = 0;
        pgm_en = 1'b1; pgm_start = 1'b1;
        wait_cycle();
        pgm_start = 1'b0;
        for (int c = 1; c <= 1000; c++) begin
            wait_cycle();
            if (otp_pgm && otp_addr == 4'd5) begin found = 1; break; end
        end
        checks++; if (found !== 1) begin errors++; $display("[TB] FAIL rst_reach_word5: got %0d expected 1", found); end
        repeat (30) wait_cycle();
        checks++; if (otp_pgm !== 1'b1) begin errors++; $display("[TB] FAIL rst_pgm_active: got %b expected 1", otp_pgm); end
        rfw0 = rfw_cnt;
        otp_rst_n = 1'b0;
        @(posedge osc_clk);
        #1;
        checks++; if (otp_pgm !== 1'b0 || rf_wr !== 1'b0) begin errors++; $display("[TB] FAIL rst_abort: got pgm=%b rf_wr=%b expected 0 0", otp_pgm, rf_wr); end
        repeat (2) wait_cycle();
        checks++; if (load_done !== 1'b0 || otp_rd !== 1'b0) begin errors++; $display("[TB] FAIL rst_hold: got done=%b rd=%b expected 0 0", load_done, otp_rd); end
        otp_rst_n = 1'b1;
        #1;
        checks++; if (otp_rd !== 1'b1 || otp_addr !== 4'd0) begin errors++; $display("[TB] FAIL rst_restart_rd: got rd=%b addr=%0d expected 1 0", otp_rd, otp_addr); end
        for (int n = 1; n <= 96; n++) begin
            wait_cycle();
            if (n == 95) begin
                checks++; if (load_done !== 1'b0) begin errors++; $display("[TB] FAIL rst_load_done_early: got %b expected 0", load_done); end
            end
        end
        checks++; if (load_done !== 1'b1) begin errors++; $display("[TB] FAIL rst_load_done: got %b expected 1", load_done); end
        checks++; if (rfw_cnt - rfw0 !== 16) begin errors++; $display("[TB] FAIL rst_rf_writes: got %0d expected 16", rfw_cnt - rfw0); end
        checks++; if (rf_mem[5] !== 8'hA5) begin errors++; $display("[TB] FAIL rst_word5: got %h expected a5", rf_mem[5]); end
    endtask

    initial begin
        $display("[TB] otp_xbus_ctrl directed test start");
        test_reset();
        test_load();
        test_i2c();
        test_program();
        test_pgm_invalid();
        test_pgm_with_i2c();
        test_reset_mid_pgm();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
